mips_dump_sequencer: RTL and testbench
======================================

// Module: mips_dump_sequencer
// PURPOSE
//  Controller between the debug FSM and UART transmitter. On a start pulse it walks the MIPS state:
//  PC, register file, data memory window, ALU result. It drives the register-number and memory-address
//  probes into the pipeline, latches each 32-bit word, and serializes it MSB-first as 4 bytes using the
//  tx_ready/tx_done handshake. The debug unit reuses it after every step and after continuous-run halt.
// PARAMETERS
//  NB         32  probe/data word width (bytes per word = NB/DATA_BITS = 4)
//  DATA_BITS   8  UART byte width
//  N_REGS     32  registers dumped, numbers 0..N_REGS-1
//  MEM_WORDS  32  data-memory words dumped
//  ADDR_STEP   4  memory address increment per word (byte addressing)
//  READ_LAT    1  cycles from probe change to valid i_mips_register/i_mips_mem_data
// PORTS
//  i_clk                  in   1          system clock
//  i_reset                in   1          asynchronous reset, active-low
//  i_start                in   1          1-cycle request to begin a dump; ignored while o_busy=1
//  i_uart_tx_done         in   1          transmitter finished current byte (1-cycle pulse)
//  i_mips_pc              in   NB         current PC
//  i_mips_register        in   NB         register-file read data for o_mips_register_number
//  i_mips_mem_data        in   NB         data-memory read data for o_mips_memory_address
//  i_mips_alu_result      in   NB         ALU result
//  o_uart_tx_ready        out  1          1-cycle start pulse to transmitter
//  o_uart_tx_data         out  DATA_BITS  byte to transmit, stable from tx_ready until tx_done
//  o_mips_register_number out  NB         register probe index
//  o_mips_memory_address  out  NB         memory probe address
//  o_busy                 out  1          dump in progress
//  o_done                 out  1          1-cycle pulse after the last byte's tx_done
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, item/byte counters 0; async assert, sync release to i_clk.
//  Item order: item0=PC, items 1..N_REGS=reg 0..N_REGS-1, next MEM_WORDS items=mem word k at address k*ADDR_STEP,
//   last item=ALU result. Total bytes = 4*(N_REGS+MEM_WORDS+2) = 264 at defaults.
//  FSM: IDLE -> (i_start) SETUP -> LOAD -> SEND -> WAIT_TX -> NEXT -> {SETUP | SEND | DONE} -> IDLE.
//   IDLE   : o_busy=0; on i_start, clear counters, set o_busy=1 on the next edge.
//   SETUP  : drive probe for the current item; wait READ_LAT cycles (counter); PC/ALU items still wait.
//   LOAD   : latch selected input word into the NB-bit shift register; byte index=0.
//   SEND   : o_uart_tx_data=shreg[NB-1 -: DATA_BITS]; o_uart_tx_ready=1 for exactly this cycle.
//   WAIT_TX: hold data; stay until i_uart_tx_done=1.
//   NEXT   : shift left DATA_BITS; byte<3 -> byte++, SEND; byte==3 and not last item -> item++, SETUP;
//            last item -> DONE.
//   DONE   : o_done=1 for one cycle, o_busy=0 on exit, back to IDLE.
//  Probe outputs hold their last value after the dump (reg N_REGS-1, addr (MEM_WORDS-1)*ADDR_STEP) until next start.
//  i_uart_tx_done outside WAIT_TX: ignored. tx_done in the same cycle as SEND: ignored (not a completion).
//  i_start during busy, including the DONE cycle: dropped, no queueing.
//  Reset mid-dump: immediate abort to IDLE with zeroed outputs; partially sent word not resumed.
//  Latency: i_start -> first o_uart_tx_ready = 2+READ_LAT cycles.
//   Last tx_done -> o_done = 2 cycles.
//  Counters: item counter width clog2(N_REGS+MEM_WORDS+2); memory address = word_idx*ADDR_STEP, truncated to NB bits.
// STRUCTURE
//  Shared package/header: FSM state encodings (3-bit localparams), BYTES_PER_WORD, item-range boundary constants.
//  One natural sub-module: word_serializer (load NB word, emit MSB-first bytes, byte_last flag); FSM/counters in top.
// TESTING
//  T1 reset: hold i_reset=0 mid-dump (byte 37) -> all outputs 0 next cycle; no tx_ready after release until i_start.
//  T2 full dump, tx_done 10 cycles after each tx_ready, PC=0x0000_0040, reg k=k, mem k=0xA500_0000|k, ALU=0xDEADBEEF
//     -> 264 bytes; first 00 00 00 40; reg 5 = 00 00 00 05; last DE AD BE EF; one o_done pulse.
//  T3 probes: capture o_mips_memory_address at each mem LOAD -> 0,4,...,124; register numbers 0..31, in order.
//  T4 handshake: tx_done delayed 1..50 random cycles, extra tx_done pulses in IDLE/SETUP, tx_done same cycle
//     as SEND -> byte stream identical to T2; each tx_ready exactly 1 cycle; data stable until tx_done.
//  T5 i_start repeated every 5 cycles during dump -> exactly one dump (264 bytes); new i_start after o_done
//     -> second identical dump.
//  T6 READ_LAT=2 build: model returns data 2 cycles after probe change -> values correct; latency = 4 cycles.

Source files
------------

// File: rtl/mips_dump_sequencer_pkg.sv
// Shared constants for the MIPS state dump sequencer: FSM encodings, item-range
// boundaries and the item classification helper.
package mips_dump_sequencer_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam int DEF_NB         = 32;
    localparam int DEF_DATA_BITS  = 8;
    localparam int BYTES_PER_WORD = DEF_NB / DEF_DATA_BITS;

    typedef enum logic [1:0] {
        ITEM_PC  = 2'd0,
        ITEM_REG = 2'd1,
        ITEM_MEM = 2'd2,
        ITEM_ALU = 2'd3
    } item_kind_e;

    // Item 0 is the PC, then the register file, then the memory window, then the ALU result.
    function automatic int first_reg_item();
        return 1;
    endfunction

    function automatic int first_mem_item(input int n_regs);
        return n_regs + 1;
    endfunction

    function automatic int last_item(input int n_regs, input int mem_words);
        return n_regs + mem_words + 1;
    endfunction

    function automatic item_kind_e item_kind(input int item, input int n_regs, input int mem_words);
        if (item < first_reg_item())
            return ITEM_PC;
        else if (item < first_mem_item(n_regs))
            return ITEM_REG;
        else if (item < last_item(n_regs, mem_words))
            return ITEM_MEM;
        else
            return ITEM_ALU;
    endfunction

endpackage

// File: rtl/mips_dump_sequencer_word_serializer.sv
// Holds one probe word and presents it MSB-first, one byte at a time, with a
// flag marking the final byte of the word.
module mips_dump_sequencer_word_serializer #(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [NB-1:0]        word_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_last_o
);

    localparam int BYTES = NB / DATA_BITS;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    logic [NB-1:0]    shreg_q;
    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else if (load_i) begin
            shreg_q <= word_i;
            idx_q   <= '0;
        end else if (shift_i) begin
            shreg_q <= shreg_q << DATA_BITS;
            idx_q   <= idx_q + IDX_W'(1);
        end
    end

    assign byte_o      = shreg_q[NB-1 -: DATA_BITS];
    assign byte_last_o = (idx_q == LAST_IDX);

endmodule

// File: rtl/mips_dump_sequencer.sv
// Walks PC, register file, data-memory window and ALU result, streaming each
// word MSB-first to the UART transmitter over the tx_ready/tx_done handshake.
//
// state   | meaning
// IDLE    | waiting for i_start, not busy
// SETUP   | probe driven for current item, waiting out read latency
// LOAD    | capture selected word into the serializer
// SEND    | one-cycle tx_ready with current byte
// WAIT_TX | hold byte until transmitter reports done
// NEXT    | advance byte, item, or finish
// DONE    | one-cycle completion pulse
module mips_dump_sequencer
    import mips_dump_sequencer_pkg::*;
#(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8,
    parameter int N_REGS    = 32,
    parameter int MEM_WORDS = 32,
    parameter int ADDR_STEP = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_uart_tx_done,
    input  logic [NB-1:0]        i_mips_pc,
    input  logic [NB-1:0]        i_mips_register,
    input  logic [NB-1:0]        i_mips_mem_data,
    input  logic [NB-1:0]        i_mips_alu_result,
    output logic                 o_uart_tx_ready,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic [NB-1:0]        o_mips_register_number,
    output logic [NB-1:0]        o_mips_memory_address,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int N_ITEMS = N_REGS + MEM_WORDS + 2;
    localparam int ITEM_W  = $clog2(N_ITEMS);
    localparam int LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [ITEM_W-1:0] LAST_ITEM = ITEM_W'(last_item(N_REGS, MEM_WORDS));
    localparam logic [ITEM_W-1:0] MEM_BASE  = ITEM_W'(first_mem_item(N_REGS));
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LAT - 1);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic [2:0]        state_q, state_d;
    logic [ITEM_W-1:0] item_q, item_d, item_nx, mem_idx_nx;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [NB-1:0]     reg_num_q, reg_num_d;
    logic [NB-1:0]     mem_addr_q, mem_addr_d;
    logic [NB-1:0]     word_sel;
    logic              ser_load, ser_shift, byte_last;
    item_kind_e        kind_cur, kind_nx;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1] & i_reset;

    assign item_nx    = item_q + ITEM_W'(1);
    assign mem_idx_nx = item_nx - MEM_BASE;
    assign kind_cur   = item_kind(int'(item_q), N_REGS, MEM_WORDS);
    assign kind_nx    = item_kind(int'(item_nx), N_REGS, MEM_WORDS);

    always_comb begin
        word_sel = i_mips_alu_result;
        case (kind_cur)
            ITEM_PC:  word_sel = i_mips_pc;
            ITEM_REG: word_sel = i_mips_register;
            ITEM_MEM: word_sel = i_mips_mem_data;
            default:  word_sel = i_mips_alu_result;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        item_d     = item_q;
        lat_d      = lat_q;
        reg_num_d  = reg_num_q;
        mem_addr_d = mem_addr_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d    = ST_SETUP;
                    item_d     = '0;
                    lat_d      = LAT_INIT;
                    reg_num_d  = '0;
                    mem_addr_d = '0;
                end
            end
            ST_SETUP: begin
                if (lat_q == '0) state_d = ST_LOAD;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            ST_LOAD: begin
                ser_load = 1'b1;
                state_d  = ST_SEND;
            end
            ST_SEND:    state_d = ST_WAIT_TX;
            ST_WAIT_TX: if (i_uart_tx_done) state_d = ST_NEXT;
            ST_NEXT: begin
                ser_shift = 1'b1;
                if (!byte_last) begin
                    state_d = ST_SEND;
                end else if (item_q == LAST_ITEM) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETUP;
                    item_d  = item_nx;
                    lat_d   = LAT_INIT;
                    // Probes move on SETUP entry so the read latency counts from here.
                    if (kind_nx == ITEM_REG)
                        reg_num_d = NB'(item_nx - ITEM_W'(1));
                    else if (kind_nx == ITEM_MEM)
                        mem_addr_d = NB'(mem_idx_nx) * NB'(ADDR_STEP);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            item_q     <= '0;
            lat_q      <= '0;
            reg_num_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            item_q     <= item_d;
            lat_q      <= lat_d;
            reg_num_q  <= reg_num_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    mips_dump_sequencer_word_serializer #(
        .NB        (NB),
        .DATA_BITS (DATA_BITS)
    ) u_serializer (
        .clk_i       (i_clk),
        .rst_ni      (rst_n),
        .load_i      (ser_load),
        .shift_i     (ser_shift),
        .word_i      (word_sel),
        .byte_o      (o_uart_tx_data),
        .byte_last_o (byte_last)
    );

    assign o_uart_tx_ready        = (state_q == ST_SEND);
    assign o_busy                 = (state_q != ST_IDLE);
    assign o_done                 = (state_q == ST_DONE);
    assign o_mips_register_number = reg_num_q;
    assign o_mips_memory_address  = mem_addr_q;

endmodule

// File: tb/tb_mips_dump_sequencer.sv
// Directed bench for mips_dump_sequencer: default build plus a small READ_LAT=2 build.
module tb_mips_dump_sequencer;

    localparam int NR    = 32;
    localparam int MW    = 32;
    localparam int TOTAL = 4 * (NR + MW + 2);
    localparam int NR2   = 4;
    localparam int MW2   = 4;
    localparam int TOTAL2 = 4 * (NR2 + MW2 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, tx_done, start2, tx_done2;
    logic [31:0] pc, alu, reg_data, mem_data, reg_d1, mem_d1, reg_data2, mem_data2;
    logic        tx_ready, busy, done, tx_ready2, busy2, done2;
    logic [7:0]  tx_data, tx_data2;
    logic [31:0] reg_num, mem_addr, reg_num2, mem_addr2;

    mips_dump_sequencer dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_uart_tx_done(tx_done),
        .i_mips_pc(pc), .i_mips_register(reg_data), .i_mips_mem_data(mem_data),
        .i_mips_alu_result(alu), .o_uart_tx_ready(tx_ready), .o_uart_tx_data(tx_data),
        .o_mips_register_number(reg_num), .o_mips_memory_address(mem_addr),
        .o_busy(busy), .o_done(done)
    );

    mips_dump_sequencer #(.N_REGS(NR2), .MEM_WORDS(MW2), .READ_LAT(2)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_start(start2), .i_uart_tx_done(tx_done2),
        .i_mips_pc(pc), .i_mips_register(reg_data2), .i_mips_mem_data(mem_data2),
        .i_mips_alu_result(alu), .o_uart_tx_ready(tx_ready2), .o_uart_tx_data(tx_data2),
        .o_mips_register_number(reg_num2), .o_mips_memory_address(mem_addr2),
        .o_busy(busy2), .o_done(done2)
    );

    // Pipeline models: one register stage for dut, two for dut2.
    always @(posedge clk) begin
        reg_data  <= reg_num;
        mem_data  <= 32'hA500_0000 | (mem_addr >> 2);
        reg_d1    <= reg_num2;
        mem_d1    <= 32'hA500_0000 | (mem_addr2 >> 2);
        reg_data2 <= reg_d1;
        mem_data2 <= mem_d1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] cap[$];
    logic [7:0] ref_stream[$];

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int nr, input int mw);
        int item = i / 4;
        int b = i % 4;
        logic [31:0] w;
        if (item == 0)             w = 32'h0000_0040;
        else if (item <= nr)       w = 32'(item - 1);
        else if (item <= nr + mw)  w = 32'hA500_0000 | 32'(item - nr - 1);
        else                       w = 32'hDEAD_BEEF;
        return w[31 - 8*b -: 8];
    endfunction

    function automatic int stream_errors(input int nr, input int mw);
        int errs = 0;
        foreach (cap[i]) if (cap[i] !== exp_byte(i, nr, mw)) errs++;
        return errs;
    endfunction

    // Entered just after a rising edge; drives i_start and plays the transmitter.
    task automatic run_dump(input bit rand_delay, input bit noise, input bit restart,
                            input int abort_at, output int nbytes, output int ndone);
        int cnt = 0;
        int last_done = -100;
        int after = 0;
        bit waiting = 0;
        bit prev_ready = 0;
        logic [7:0] cur = '0;
        cap.delete();
        nbytes = 0;
        ndone = 0;
        start = 1'b1;
        for (int c = 0; c < 40000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            tx_done = 1'b0;
            if (c == 0) check("busy_after_start", busy, 1'b1);
            if (restart && busy && (c % 5 == 0)) start = 1'b1;
            if (tx_ready) begin
                check("tx_ready_one_cycle", prev_ready, 1'b0);
                if (nbytes == 0) check("start_latency", c + 1, 3);
                if (nbytes % 4 == 0) begin
                    int item = nbytes / 4;
                    if (item >= 1 && item <= NR)
                        check("reg_probe", reg_num, 32'(item - 1));
                    else if (item > NR && item <= NR + MW)
                        check("mem_probe", mem_addr, 32'(4 * (item - NR - 1)));
                end
                cap.push_back(tx_data);
                nbytes++;
                cur = tx_data;
                waiting = 1'b1;
                cnt = rand_delay ? int'($urandom_range(1, 50)) : 10;
                if (noise) tx_done = 1'b1;
            end else if (waiting) begin
                check("data_stable", tx_data, cur);
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    waiting = 1'b0;
                    last_done = c;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                tx_done = 1'b1;
            end
            prev_ready = tx_ready;
            if (done) begin
                ndone++;
                check("done_latency", c - last_done, 2);
            end
            if (abort_at >= 0 && nbytes == abort_at) return;
            if (ndone > 0 && !busy) begin
                after++;
                if (after >= 10) break;
            end
        end
        tx_done = 1'b0;
    endtask

    initial begin
        int nb, nd, nb2, nd2, cnt2, errs;
        bit w2;
        bit seen;
        logic [7:0] cap2[$];

        vecs[0]  = '{0,   8'h00}; vecs[1]  = '{1,   8'h00}; vecs[2]  = '{2,   8'h00};
        vecs[3]  = '{3,   8'h40}; vecs[4]  = '{24,  8'h00}; vecs[5]  = '{25,  8'h00};
        vecs[6]  = '{26,  8'h00}; vecs[7]  = '{27,  8'h05}; vecs[8]  = '{132, 8'hA5};
        vecs[9]  = '{135, 8'h00}; vecs[10] = '{259, 8'h1F}; vecs[11] = '{260, 8'hDE};
        vecs[12] = '{261, 8'hAD}; vecs[13] = '{262, 8'hBE}; vecs[14] = '{263, 8'hEF};

        rst_n = 1'b0; start = 1'b0; tx_done = 1'b0; start2 = 1'b0; tx_done2 = 1'b0;
        pc = 32'h0000_0040; alu = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", {tx_ready, tx_data, reg_num, mem_addr, busy, done}, '0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;

        // Full dump with fixed 10-cycle transmitter.
        run_dump(1'b0, 1'b0, 1'b0, -1, nb, nd);
        check("t2_bytes", nb, TOTAL);
        check("t2_done_pulses", nd, 1);
        check("t2_stream_errors", stream_errors(NR, MW), 0);
        for (int i = 0; i < 15; i++)
            check($sformatf("vec_byte%0d", vecs[i].idx),
                  (vecs[i].idx < cap.size()) ? cap[vecs[i].idx] : 8'hxx, vecs[i].exp);
        check("probe_reg_hold", reg_num, 32'd31);
        check("probe_addr_hold", mem_addr, 32'd124);
        check("idle_after_dump", busy, 1'b0);
        ref_stream = cap;

        // Random handshake delay plus stray and same-cycle tx_done pulses.
        run_dump(1'b1, 1'b1, 1'b0, -1, nb, nd);
        check("t4_bytes", nb, TOTAL);
        check("t4_done_pulses", nd, 1);
        check("t4_same_as_t2", (cap == ref_stream), 1'b1);

        // i_start hammered during the dump, then a clean second dump.
        run_dump(1'b0, 1'b0, 1'b1, -1, nb, nd);
        check("t5_bytes", nb, TOTAL);
        check("t5_done_pulses", nd, 1);
        check("t5_stream_errors", stream_errors(NR, MW), 0);
        run_dump(1'b0, 1'b0, 1'b0, -1, nb, nd);
        check("t5_second_bytes", nb, TOTAL);
        check("t5_second_same", (cap == ref_stream), 1'b1);

        // Reset in the middle of a dump.
        run_dump(1'b0, 1'b0, 1'b0, 37, nb, nd);
        check("t1_reached_byte37", nb, 37);
        tx_done = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t1_reset_outputs", {tx_ready, tx_data, reg_num, mem_addr, busy, done}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (tx_ready || busy) seen = 1'b1;
        end
        check("t1_quiet_after_release", seen, 1'b0);

        // READ_LAT=2 build with a two-stage read model.
        nb2 = 0; nd2 = 0; cnt2 = 0; w2 = 1'b0;
        start2 = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            tx_done2 = 1'b0;
            if (tx_ready2) begin
                if (nb2 == 0) check("t6_start_latency", c + 1, 4);
                cap2.push_back(tx_data2);
                nb2++;
                w2 = 1'b1;
                cnt2 = 3;
            end else if (w2) begin
                cnt2--;
                if (cnt2 == 0) begin
                    tx_done2 = 1'b1;
                    w2 = 1'b0;
                end
            end
            if (done2) nd2++;
            if (nd2 > 0 && !busy2) break;
        end
        check("t6_bytes", nb2, TOTAL2);
        check("t6_done_pulses", nd2, 1);
        errs = 0;
        foreach (cap2[i]) if (cap2[i] !== exp_byte(i, NR2, MW2)) errs++;
        check("t6_stream_errors", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
